// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the write-back stage.
// Contents: XLEN, the LOAD major opcode, and the load funct3 encodings.
package rv32i_pkg;

    localparam int unsigned XLEN        = 32;
    localparam logic [6:0]  OPCODE_LOAD = 7'b0000011;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_e;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus bundle for the write-back stage.
// Carries the pipeline controls (STALL/FLUSH), the incoming M_* bundle, the
// decode read ports and the latched W_* / INSTRET results.
// master: upstream pipeline (drives M_*, controls, read addresses)
// slave : wb_regfile
interface wb_regfile_if;
    import rv32i_pkg::*;

    logic            STALL;
    logic            FLUSH;
    logic [XLEN-1:0] M_PC;
    logic [31:0]     M_INST;
    logic            M_VALID;
    logic [4:0]      M_REG_D;
    logic [XLEN-1:0] M_REG_D_V;
    logic [3:0]      M_LOAD_STRB;
    logic [XLEN-1:0] M_LOAD_DATA;
    logic [4:0]      RS1_ADDR;
    logic [4:0]      RS2_ADDR;
    logic [XLEN-1:0] RS1_DATA;
    logic [XLEN-1:0] RS2_DATA;
    logic [XLEN-1:0] W_PC;
    logic [31:0]     W_INST;
    logic            W_VALID;
    logic [4:0]      W_REG_D;
    logic [XLEN-1:0] W_REG_D_V;
    logic [63:0]     INSTRET;

    modport master (
        output STALL, FLUSH, M_PC, M_INST, M_VALID, M_REG_D, M_REG_D_V,
               M_LOAD_STRB, M_LOAD_DATA, RS1_ADDR, RS2_ADDR,
        input  RS1_DATA, RS2_DATA, W_PC, W_INST, W_VALID, W_REG_D,
               W_REG_D_V, INSTRET
    );

    modport slave (
        input  STALL, FLUSH, M_PC, M_INST, M_VALID, M_REG_D, M_REG_D_V,
               M_LOAD_STRB, M_LOAD_DATA, RS1_ADDR, RS2_ADDR,
        output RS1_DATA, RS2_DATA, W_PC, W_INST, W_VALID, W_REG_D,
               W_REG_D_V, INSTRET
    );

endinterface

// File: rtl/regfile.sv
// 32 x XLEN integer register storage.
// Ports: i_clk, i_rst_n (sync active-low clear of all entries),
//        i_we/i_waddr/i_wdata (one write port),
//        i_raddr1/o_rdata1, i_raddr2/o_rdata2 (asynchronous reads).
// x0 protection and bypass are handled by the caller.
module regfile
    import rv32i_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_regs [32];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_regs[i_raddr1];
    assign o_rdata2 = r_regs[i_raddr2];

endmodule

// File: rtl/wb_regfile.sv
// RV32I write-back stage: W latch, load lane extraction, register commit,
// bypassed decode read ports and retired-instruction counter.
// Ports: CLK (rising edge), RST (sync active-low), bus (wb_regfile_if.slave)
// carrying STALL/FLUSH, the M_* bundle, RS1/RS2 read ports, W_* and INSTRET.
module wb_regfile
    import rv32i_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    wb_regfile_if.slave   bus
);

    logic [XLEN-1:0] r_w_pc;
    logic [31:0]     r_w_inst;
    logic            r_w_valid;
    logic [4:0]      r_w_reg_d;
    logic [XLEN-1:0] r_w_reg_d_v;
    logic [63:0]     r_instret;

    logic            w_is_load;
    logic [1:0]      w_off;
    logic            w_byte_ok;
    logic            w_half_ok;
    logic            w_word_ok;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_load_val;
    logic [XLEN-1:0] w_next_val;
    logic            w_rf_we;
    logic [XLEN-1:0] w_rf_rd1;
    logic [XLEN-1:0] w_rf_rd2;

    assign w_is_load = (bus.M_INST[6:0] == OPCODE_LOAD);

    // Strobe pattern decides both the lane offset and which access sizes it
    // can legally belong to.
    always_comb begin
        w_off     = 2'd0;
        w_byte_ok = 1'b0;
        w_half_ok = 1'b0;
        w_word_ok = 1'b0;
        case (bus.M_LOAD_STRB)
            4'b0001: begin w_off = 2'd0; w_byte_ok = 1'b1; end
            4'b0010: begin w_off = 2'd1; w_byte_ok = 1'b1; end
            4'b0100: begin w_off = 2'd2; w_byte_ok = 1'b1; end
            4'b1000: begin w_off = 2'd3; w_byte_ok = 1'b1; end
            4'b0011: begin w_off = 2'd0; w_half_ok = 1'b1; end
            4'b1100: begin w_off = 2'd2; w_half_ok = 1'b1; end
            4'b1111: begin w_off = 2'd0; w_word_ok = 1'b1; end
            default: ;
        endcase
    end

    assign w_shifted = bus.M_LOAD_DATA >> {w_off, 3'b000};

    // Any funct3/strobe mismatch yields 0; the write itself still happens.
    always_comb begin
        w_load_val = '0;
        case (funct3_e'(bus.M_INST[14:12]))
            F3_LB:  if (w_byte_ok) w_load_val = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LBU: if (w_byte_ok) w_load_val = {24'd0, w_shifted[7:0]};
            F3_LH:  if (w_half_ok) w_load_val = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LHU: if (w_half_ok) w_load_val = {16'd0, w_shifted[15:0]};
            F3_LW:  if (w_word_ok) w_load_val = w_shifted;
            default: w_load_val = '0;
        endcase
    end

    assign w_next_val = w_is_load ? w_load_val : bus.M_REG_D_V;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_w_pc      <= '0;
            r_w_inst    <= '0;
            r_w_valid   <= 1'b0;
            r_w_reg_d   <= '0;
            r_w_reg_d_v <= '0;
        end else if (bus.STALL) begin
            r_w_pc      <= r_w_pc;
            r_w_inst    <= r_w_inst;
            r_w_valid   <= r_w_valid;
            r_w_reg_d   <= r_w_reg_d;
            r_w_reg_d_v <= r_w_reg_d_v;
        end else if (bus.FLUSH) begin
            r_w_pc      <= '0;
            r_w_inst    <= '0;
            r_w_valid   <= 1'b0;
            r_w_reg_d   <= '0;
            r_w_reg_d_v <= '0;
        end else begin
            r_w_pc      <= bus.M_PC;
            r_w_inst    <= bus.M_INST;
            r_w_valid   <= bus.M_VALID;
            r_w_reg_d   <= bus.M_REG_D;
            r_w_reg_d_v <= w_next_val;
        end
    end

    // The entry in W retires on any non-stalled edge, including a flush edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_instret <= '0;
        end else if (r_w_valid && !bus.STALL) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign w_rf_we = r_w_valid && (r_w_reg_d != 5'd0);

    regfile u_regfile (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_we     (w_rf_we),
        .i_waddr  (r_w_reg_d),
        .i_wdata  (r_w_reg_d_v),
        .i_raddr1 (bus.RS1_ADDR),
        .i_raddr2 (bus.RS2_ADDR),
        .o_rdata1 (w_rf_rd1),
        .o_rdata2 (w_rf_rd2)
    );

    always_comb begin
        bus.RS1_DATA = w_rf_rd1;
        if (bus.RS1_ADDR == 5'd0) begin
            bus.RS1_DATA = '0;
        end else if (r_w_valid && (bus.RS1_ADDR == r_w_reg_d)) begin
            bus.RS1_DATA = r_w_reg_d_v;
        end
    end

    always_comb begin
        bus.RS2_DATA = w_rf_rd2;
        if (bus.RS2_ADDR == 5'd0) begin
            bus.RS2_DATA = '0;
        end else if (r_w_valid && (bus.RS2_ADDR == r_w_reg_d)) begin
            bus.RS2_DATA = r_w_reg_d_v;
        end
    end

    assign bus.W_PC      = r_w_pc;
    assign bus.W_INST    = r_w_inst;
    assign bus.W_VALID   = r_w_valid;
    assign bus.W_REG_D   = r_w_reg_d;
    assign bus.W_REG_D_V = r_w_reg_d_v;
    assign bus.INSTRET   = r_instret;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage of the RV32I pipeline, directly downstream of the memory-access stage. Each cycle it latches that stage's M_* bundle and, for loads, extracts and sign- or zero-extends the loaded lane. It commits results to the 32×32 integer register file, serves the two decode-stage read ports with write-through bypass, and counts retired instructions.

## Interface
- No parameters. XLEN is fixed at 32.
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-low (RST=0 resets on the next CLK edge)
- STALL  in  1  hold the W latch
- FLUSH  in  1  load a bubble into the W latch
- M_PC  in  32  PC of incoming instruction
- M_INST  in  32  incoming instruction word
- M_VALID  in  1  incoming slot holds a real instruction
- M_REG_D  in  5  destination register
- M_REG_D_V  in  32  non-load result value
- M_LOAD_STRB  in  4  byte lanes read by a load
- M_LOAD_DATA  in  32  raw word returned by data memory
- RS1_ADDR, RS2_ADDR  in  5 each  decode read addresses
- RS1_DATA, RS2_DATA  out  32 each  read data (combinational)
- W_PC, W_INST  out  32 each  latched PC and instruction
- W_VALID  out  1  latched valid
- W_REG_D  out  5  latched destination register
- W_REG_D_V  out  32  final write value, used by upstream forwarding
- INSTRET  out  64  retired-instruction count

## Operation
- Load decode: load when M_INST[6:0]=0000011, with funct3=M_INST[14:12].
- Lane offset comes from M_LOAD_STRB.
  - Byte: 0001/0010/0100/1000 → offset 0/1/2/3.
  - Half: 0011/1100 → offset 0/2.
  - Word: 1111.
- Extraction: value = M_LOAD_DATA >> (8·offset), then extend by funct3.
  - LB: sign-extend 8 bits. LBU: zero-extend 8 bits.
  - LH: sign-extend 16 bits. LHU: zero-extend 16 bits.
  - LW: pass 32 bits unchanged.
- Illegal strobe/funct3 combination on a valid load: write value is 0, and the register is still written.
- Non-load instructions take M_REG_D_V unchanged.
- W latch, priority order:
  1. RST=0 → all fields 0.
  2. STALL → hold.
  3. FLUSH → all fields 0 (bubble).
  4. Otherwise capture M_* and the extracted value.
- Register write: every edge where W_VALID=1 and W_REG_D≠0, regs[W_REG_D] ← W_REG_D_V. A repeated write during STALL is idempotent. x0 is never written.
- Read ports, combinational:
  - Address 0 → 0.
  - Else if address = W_REG_D and W_VALID=1 → W_REG_D_V (bypass).
  - Else → regs[addr].
- Retire: INSTRET increments by 1 on each edge where W_VALID=1 and STALL=0. FLUSH does not cancel the entry already in W; it still retires.
- INSTRET wraps from 2^64−1 to 0.

## Timing
- Reset values: all W_* = 0, INSTRET = 0, all 32 registers = 0. RS*_DATA therefore read 0.
- Latency: M_* sampled at edge n appear on W_* after edge n. The register file holds the value after edge n+1, and INSTRET reflects the retire after edge n+1.
- Bypass makes a value readable on RS*_DATA in the same cycle it is visible on W_*, with zero bubbles.
- Simultaneous STALL and FLUSH: STALL wins, the latch holds, and nothing retires.
- Reset while W is valid: the entry is discarded, with no register write and no retire on the reset edge.
- Back-to-back writes to the same register: the later instruction overwrites the earlier one. Bypass always reflects the W entry.

## Structure
- Shared package `rv32i_pkg` holds:
  - OPCODE_LOAD = 7'b0000011
  - funct3 codes F3_LB/LH/LW/LBU/LHU
  - XLEN = 32
- Sub-module `regfile`: 32×32 storage, one write port, two async read ports, synchronous active-low clear.
- Load extraction and bypass stay inline in wb_regfile.

## Test plan
- Reset: hold RST=0 for 2 cycles with M_VALID=1 → all W_* = 0, INSTRET = 0, RS1_DATA = 0 for every address.
- ALU write plus bypass: M_VALID=1, M_REG_D=5, M_REG_D_V=0x1234_5678, RS1_ADDR=5.
  - Cycle after capture: RS1_DATA = 0x12345678 via bypass.
  - Next cycle, with a bubble in W: still 0x12345678, now read from the register file.
  - INSTRET = 1.
- Loads with M_LOAD_DATA=0x80F0_7F81:
  - LB, strb 0001 → 0xFFFFFF81
  - LBU, strb 0100 → 0x000000F0
  - LH, strb 1100 → 0xFFFF80F0
  - LHU, strb 0011 → 0x00007F81
  - LW, strb 1111 → 0x80F07F81
- x0 guard: M_REG_D=0, M_REG_D_V=0xDEAD_BEEF → RS1_ADDR=0 reads 0, and INSTRET still increments.
- Stall/flush: valid entry in W.
  - STALL=1 for 3 cycles → W_* held, INSTRET unchanged.
  - STALL=1 with FLUSH=1 → hold.
  - FLUSH alone → W_VALID=0 next cycle, INSTRET +1 exactly once.
- Wrap: preload INSTRET = 0xFFFF_FFFF_FFFF_FFFF through the bench backdoor, then retire one instruction → INSTRET = 0.
